// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
//   State encoding for the multicycle control FSM and the select/opcode codes it
//   drives onto the datapath: ALUControl, ResultSrc, ALUSrcB and ImmSrc. Also holds
//   two helpers that classify a data-processing cmd field.
//   No ports (package).
package multicycle_ctrl_pkg;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXECR  = 4'd7;
   localparam logic [3:0] S_EXECI  = 4'd8;
   localparam logic [3:0] S_ALUWB  = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   // Only ADD, SUB, AND and ORR are implemented by the shared ALU.
   function automatic logic dp_cmd_legal(input logic [3:0] cmd);
      return (cmd == 4'b0100) || (cmd == 4'b0010) ||
             (cmd == 4'b0000) || (cmd == 4'b1100);
   endfunction

   function automatic logic [1:0] dp_alu_ctl(input logic [3:0] cmd);
      logic [1:0] ctl;
      case (cmd)
         4'b0010: ctl = ALU_SUB;
         4'b0000: ctl = ALU_AND;
         4'b1100: ctl = ALU_ORR;
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/mc_instr_decode.sv
// mc_instr_decode
//   Combinational instruction classifier for the multicycle controller.
//   Ports:
//     instr_hi     in   8  Instr[27:20] (op, I, cmd, S/L)
//     decode_next  out  4  state to enter after DECODE
//     alu_control  out  2  ALU operation for a data-processing cmd
//     flag_mask    out  2  flag-write mask before condition gating
//     imm_src      out  2  immediate format selected by op
//     reg_src      out  2  [0] RA1 = R15 (branch), [1] RA2 = Rd (store)
//     illegal      out  1  encoding not supported by this core
module mc_instr_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [7:0] instr_hi,
   output logic [3:0] decode_next,
   output logic [1:0] alu_control,
   output logic [1:0] flag_mask,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic       illegal
);

   logic [1:0] op;
   logic [3:0] cmd;
   logic       s_bit;

   assign op    = instr_hi[7:6];
   assign cmd   = instr_hi[4:1];
   assign s_bit = instr_hi[0];

   always_comb begin
      decode_next = S_FETCH;
      illegal     = 1'b0;
      casez ({instr_hi[7:5], instr_hi[0]})
         4'b000?: decode_next = S_EXECR;
         4'b001?: decode_next = S_EXECI;
         4'b01??: decode_next = S_MEMADR;
         4'b101?: decode_next = S_BRANCH;
         default: illegal     = 1'b1;
      endcase
      // Unsupported DP opcodes (EOR, RSB, CMP, ...) are rejected as a whole.
      if (op == 2'b00 && !dp_cmd_legal(cmd)) begin
         decode_next = S_FETCH;
         illegal     = 1'b1;
      end
   end

   assign alu_control = dp_alu_ctl(cmd);

   // Logical ops leave C and V untouched.
   always_comb begin
      flag_mask = 2'b00;
      if (s_bit)
         flag_mask = (alu_control == ALU_ADD || alu_control == ALU_SUB) ? 2'b11 : 2'b10;
   end

   always_comb begin
      case (op)
         2'b01:   imm_src = IMM_MEM;
         2'b10:   imm_src = IMM_BR;
         default: imm_src = IMM_DP;
      endcase
   end

   // Stores read Rd as write data; branches read PC through RA1.
   assign reg_src = {(op == 2'b01) && !instr_hi[0], (op == 2'b10)};

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle control FSM for the ARM-subset core: sequences the shared ALU and
//   the shared instruction/data memory port through FETCH, DECODE, EXECUTE, MEMORY
//   and WRITEBACK. Every architectural write is gated by the condition result
//   registered in DECODE.
//   Configuration macro: MULTICYCLE_CTRL_PERF_EN adds CycleCnt / RetireCnt.
//   Ports:
//     CLK, Reset_n (async active-low)
//     Instr[31:0], CondEx, MemAck                      inputs
//     MemReq, MemW, AdrSrc, IRWrite, PCWrite, RegW     control strobes/selects
//     ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0], ImmSrc[1:0], RegSrc[1:0]
//     ALUControl[1:0], FlagW[1:0], IllegalInstr, State[3:0]
//     CycleCnt/RetireCnt[CNT_W-1:0]                    perf build only
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        CLK,
   input  logic        Reset_n,
   input  logic [31:0] Instr,
   input  logic        CondEx,
   input  logic        MemAck,
   output logic        MemReq,
   output logic        MemW,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegW,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUControl,
   output logic [1:0]  FlagW,
   output logic        IllegalInstr,
   output logic [3:0]  State
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] CycleCnt,
   output logic [CNT_W-1:0] RetireCnt
`endif
);

   logic [3:0] state;
   logic [3:0] next_state;
   logic       cond_ex_q;
   logic       rd_pc;

   logic [3:0] dec_next;
   logic [1:0] dec_alu;
   logic [1:0] dec_flag_mask;
   logic [1:0] dec_imm_src;
   logic [1:0] dec_reg_src;
   logic       dec_illegal;

   // Condition field, Rn and the low operand bits are consumed by the datapath.
   logic unused_bits;
   assign unused_bits = ^{Instr[31:28], Instr[19:16], Instr[11:0]} ^ (CNT_W == 0);

   mc_instr_decode u_decode (
      .instr_hi    (Instr[27:20]),
      .decode_next (dec_next),
      .alu_control (dec_alu),
      .flag_mask   (dec_flag_mask),
      .imm_src     (dec_imm_src),
      .reg_src     (dec_reg_src),
      .illegal     (dec_illegal)
   );

   assign rd_pc = (Instr[15:12] == 4'hF);
   assign State = state;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= S_IDLE;
         cond_ex_q <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_DECODE)
            cond_ex_q <= CondEx;
      end
   end

   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE:   next_state = S_FETCH;
         S_FETCH:  next_state = MemAck ? S_DECODE : S_FETCH;
         S_DECODE: next_state = dec_next;
         S_EXECR,
         S_EXECI:  next_state = S_ALUWB;
         S_ALUWB:  next_state = S_FETCH;
         // A failed condition skips the memory access entirely.
         S_MEMADR: next_state = !cond_ex_q ? S_FETCH : (Instr[20] ? S_MEMRD : S_MEMWR);
         S_MEMRD:  next_state = MemAck ? S_MEMWB : S_MEMRD;
         S_MEMWR:  next_state = MemAck ? S_FETCH : S_MEMWR;
         S_MEMWB:  next_state = S_FETCH;
         S_BRANCH: next_state = S_FETCH;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      MemReq       = 1'b0;
      MemW         = 1'b0;
      AdrSrc       = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegW         = 1'b0;
      ResultSrc    = RES_ALUOUT;
      ALUSrcA      = 1'b0;
      ALUSrcB      = SRCB_REG;
      ImmSrc       = IMM_DP;
      RegSrc       = 2'b00;
      ALUControl   = ALU_ADD;
      FlagW        = 2'b00;
      IllegalInstr = 1'b0;
      case (state)
         S_FETCH: begin
            MemReq = 1'b1;
            // PC <= PC + 4 in the same cycle the instruction is captured.
            if (MemAck) begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               ALUSrcA   = 1'b1;
               ALUSrcB   = SRCB_FOUR;
               ResultSrc = RES_ALU;
            end
         end
         S_DECODE: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = SRCB_FOUR;
            ImmSrc       = dec_imm_src;
            RegSrc       = dec_reg_src;
            IllegalInstr = dec_illegal;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
            ALUControl = dec_alu;
            FlagW      = cond_ex_q ? dec_flag_mask : 2'b00;
         end
         S_ALUWB: begin
            RegW    = cond_ex_q & ~rd_pc;
            PCWrite = cond_ex_q & rd_pc;
         end
         S_MEMADR: begin
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = IMM_MEM;
            ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
         end
         S_MEMRD: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
         end
         S_MEMWR: begin
            MemReq = 1'b1;
            MemW   = 1'b1;
            AdrSrc = 1'b1;
            RegSrc = 2'b10;
         end
         S_MEMWB: begin
            ResultSrc = RES_RDATA;
            RegW      = cond_ex_q & ~rd_pc;
            PCWrite   = cond_ex_q & rd_pc;
         end
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ImmSrc    = IMM_BR;
            ResultSrc = RES_ALU;
            PCWrite   = cond_ex_q;
         end
         default: ;
      endcase
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic retire;

   // Last state of every legal instruction, condition-failed ones included.
   assign retire = (state == S_ALUWB) || (state == S_MEMWB) || (state == S_BRANCH) ||
                   (state == S_MEMWR && MemAck) || (state == S_MEMADR && !cond_ex_q);

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         CycleCnt  <= '0;
         RetireCnt <= '0;
      end else begin
         if (state != S_IDLE)
            CycleCnt <= CycleCnt + CNT_W'(1);
         if (retire)
            RetireCnt <= RetireCnt + CNT_W'(1);
      end
   end
`endif

endmodule
